sc_stoch_to_bin: RTL and testbench



---
 rtl/sc_stoch_to_bin.sv | 157 +++++++++++++++
 tb/tb_sc_stoch_to_bin.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sc_stoch_to_bin.sv
// sc_stoch_to_bin
//
// Converts a unipolar stochastic bitstream back to binary. The block counts
// the ones in a window of 2^WIDTH valid samples, then presents the count on
// value_out. A valid/ready handshake hands the result to the consumer.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   start      begin a new window (used in IDLE, or in DONE on the handshake edge)
//   bit_in     stochastic bitstream sample
//   bit_valid  bit_in carries a sample this cycle
//   busy       high while a window is accumulating
//   out_valid  value_out holds a completed result
//   out_ready  consumer accepts the result
//   value_out  ones count of the completed window, 0..2^WIDTH
//
// Build option
//   SC_S2B_CONTINUOUS_EN : free-running back-to-back windows. The block resets
//   into ACCUM, ignores start and out_ready, and pulses out_valid for one cycle
//   at each completion. DONE is never entered.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start, counters idle
// ACCUM | counting valid samples and ones
// DONE  | result held on value_out until out_ready

module sc_stoch_to_bin #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   value_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH:0] WINDOW = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] ONE    = {{WIDTH{1'b0}}, 1'b1};

`ifdef SC_S2B_CONTINUOUS_EN
    localparam state_t RST_STATE = ACCUM;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH:0] sample_cnt;
    logic [WIDTH:0] ones_cnt;
    logic [WIDTH:0] sample_cnt_inc;
    logic [WIDTH:0] bit_ext;
    logic           take;
    logic           last;

    assign bit_ext        = {{WIDTH{1'b0}}, bit_in};
    assign sample_cnt_inc = sample_cnt + ONE;
    assign take           = (state == ACCUM) && bit_valid;
    // The accepted sample is number 2^WIDTH when the incremented count reaches the window size.
    assign last           = take && (sample_cnt_inc == WINDOW);

`ifndef SC_S2B_CONTINUOUS_EN
    logic launch;
    assign launch = start && ((state == IDLE) || ((state == DONE) && out_ready));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
`ifdef SC_S2B_CONTINUOUS_EN
        state_nxt = ACCUM;
`else
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = start ? ACCUM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`endif
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        if (state == ACCUM) begin
            busy = 1'b1;
        end
    end

    // Counters and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
            out_valid  <= 1'b0;
            value_out  <= '0;
        end else begin
`ifdef SC_S2B_CONTINUOUS_EN
            // Single-cycle pulse; re-set below only on a completion edge.
            out_valid <= 1'b0;
`else
            if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
            if (launch) begin
                sample_cnt <= '0;
                ones_cnt   <= '0;
            end
`endif
            if (take) begin
                if (last) begin
                    // The completion bit belongs only to the finishing window.
                    value_out  <= ones_cnt + bit_ext;
                    out_valid  <= 1'b1;
                    sample_cnt <= '0;
                    ones_cnt   <= '0;
                end else begin
                    sample_cnt <= sample_cnt_inc;
                    ones_cnt   <= ones_cnt + bit_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_sc_stoch_to_bin.sv
// Testbench for sc_stoch_to_bin with WIDTH=4. A driver issues windows of
// samples and pushes the expected ones count (popcount of the window's valid
// samples) into a queue; a monitor pops and compares on every handshake.

module tb_sc_stoch_to_bin;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         bit_in;
    logic         bit_valid;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   value_out;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int pulse_cyc[$];
    int cyc = 0;

    sc_stoch_to_bin #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value_out (value_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0d required=none", value_out);
            end else begin
                check("window_value", 32'(value_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window();
        start     = 1'b1;
        bit_valid = 1'b0;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
    endtask

    // Feed len valid samples taken from bits (LSB first). Gap cycles with
    // bit_valid=0 are inserted before the first gaps_fixed samples and at
    // random with probability gap_pct percent.
    task automatic feed(input logic [N-1:0] bits, input int len, input int gaps_fixed, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            if (i < gaps_fixed || (gap_pct > 0 && $urandom_range(99) < gap_pct)) begin
                bit_valid = 1'b0;
                bit_in    = (i < gaps_fixed) ? 1'b1 : 1'($urandom);
                step();
                check("busy_in_gap", 32'(busy), 1);
            end
            bit_valid = 1'b1;
            bit_in    = bits[i];
            if (i == N - 1) exp_q.push_back($countones(bits));
            step();
            if (i < N - 1) begin
                check("busy_mid", 32'(busy), 1);
                check("no_early_valid", 32'(out_valid), 0);
            end else begin
                check("latency_valid", 32'(out_valid), 1);
`ifndef SC_S2B_CONTINUOUS_EN
                check("busy_after_done", 32'(busy), 0);
`endif
            end
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
        check("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        logic [N-1:0] r;
        rst       = 1'b1;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_value", 32'(value_out), 0);
`ifdef SC_S2B_CONTINUOUS_EN
        check("reset_busy", 32'(busy), 1);
        rst = 1'b0;
        feed('1, N, 0, 0);
        feed('0, N, 0, 0);
        step();
        check("pulse_width", 32'(out_valid), 0);
        drain();
        check("pulse_count", 32'(pulse_cyc.size()), 2);
        if (pulse_cyc.size() >= 2) check("pulse_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), N);
`else
        check("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        step();

        // All ones, all zeros, alternating, valid gaps
        start_window(); feed('1, N, 0, 0); drain();
        start_window(); feed('0, N, 0, 0); drain();
        start_window(); feed(N'(16'h5555), N, 0, 0); drain();
        start_window(); feed(N'(16'h1891), N, 10, 0); drain();

        // Random windows with random gaps
        for (int k = 0; k < 6; k++) begin
            r = N'($urandom);
            start_window(); feed(r, N, 0, 30); drain();
        end

        // Reset mid-window discards the partial count
        start_window();
        feed('1, 7, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("idle_no_valid", 32'(out_valid), 0);
        end
        bit_valid = 1'b0;
        start_window(); feed('1, N, 0, 0); drain();

        // Backpressure then restart in the handshake cycle
        out_ready = 1'b0;
        r = N'($urandom);
        start_window();
        feed(r, N, 0, 20);
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_valid", 32'(out_valid), 1);
            check("hold_value", 32'(value_out), 32'($countones(r)));
        end
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("restart_valid", 32'(out_valid), 0);
        check("restart_busy", 32'(busy), 1);
        feed(N'(16'h000F), N, 0, 0);
        drain();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
